// File: rtl/serial_addsub_ctrl_if.sv
// Start/done handshake and operand/result bus between the issuing logic
// and the serial add/subtract sequencer.
interface serial_addsub_ctrl_if #(
  parameter int W = 16
);
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  modport master (
    output start, op, a, b, ci,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, op, a, b, ci,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Wide add/subtract built from one N-bit ripple slice, stepped LSB to MSB
// over W/N clocks with the inter-slice carry kept in a register.
module serial_addsub_ctrl #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_addsub_ctrl_if.slave bus
);

  localparam int NSL = W / N;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          slice_we;

  logic [N-1:0]  a_slices [NSL];
  logic [N-1:0]  b_slices [NSL];
  logic [N-1:0]  a_sl, y_sl, s_sl;
  logic [N:0]    chain;

  // Operand slices are muxed out of the latched words by the running index.
  generate
    for (genvar gi = 0; gi < NSL; gi++) begin : g_slice
      assign a_slices[gi] = a_q[gi*N +: N];
      assign b_slices[gi] = b_q[gi*N +: N];
      assign result_d[gi*N +: N] = (slice_we && (idx_q == IW'(gi))) ?
                                   s_sl : result_q[gi*N +: N];
    end
  endgenerate

  assign a_sl = a_slices[idx_q];
  assign y_sl = op_q ? ~b_slices[idx_q] : b_slices[idx_q];

  always_comb begin
    chain    = '0;
    s_sl     = '0;
    chain[0] = carry_q;
    for (int k = 0; k < N; k++) begin
      s_sl[k]      = a_sl[k] ^ y_sl[k] ^ chain[k];
      chain[k + 1] = (a_sl[k] & y_sl[k]) | (chain[k] & (a_sl[k] ^ y_sl[k]));
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    slice_we = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          carry_d = bus.op ? 1'b1 : bus.ci;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        slice_we = 1'b1;
        carry_d  = chain[N];
        idx_d    = idx_q + 1'b1;
        // Flags come from the MSB slice: carry into vs. out of the top bit.
        if (idx_q == LAST_IDX) begin
          cout_d  = chain[N];
          ovf_d   = chain[N] ^ chain[N-1];
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed vector table, handshake
// corner cases and random operations against an arithmetic reference model.
module tb_serial_addsub_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_addsub_ctrl_if #(.W(16)) bus ();

  serial_addsub_ctrl #(.W(16), .N(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        ci;
    logic [15:0] res;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole words.
  function automatic void ref_op(input logic [15:0] a, input logic [15:0] b,
                                 input logic op, input logic ci,
                                 output logic [15:0] r, output logic co, output logic ov);
    int sa, sb, s;
    logic [16:0] u;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!op) begin
      u  = {1'b0, a} + {1'b0, b} + (ci ? 17'd1 : 17'd0);
      r  = u[15:0];
      co = u[16];
      s  = sa + sb + (ci ? 1 : 0);
    end else begin
      r  = a - b;
      co = (a >= b);
      s  = sa - sb;
    end
    ov = (s > 32767) || (s < -32768);
  endfunction

  // Accept one operation and wait for done; inputs are scrambled after acceptance.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic op,
                        input logic ci, output logic [15:0] r, output logic co,
                        output logic ov, output int lat);
    bus.a = a; bus.b = b; bus.op = op; bus.ci = ci; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom);
    bus.op = 1'($urandom); bus.ci = 1'($urandom);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = bus.result; co = bus.cout; ov = bus.ovf;
  endtask

  task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic op, input logic ci, input logic [15:0] er,
                          input logic eco, input logic eov);
    logic [15:0] r;
    logic co, ov;
    int lat;
    run_op(a, b, op, ci, r, co, ov, lat);
    $display("op %s a=%h b=%h op=%0d ci=%0d -> result=%h cout=%0d ovf=%0d lat=%0d",
             name, a, b, op, ci, r, co, ov, lat);
    chk({name, "_latency"}, 32'(lat), 32'd4);
    chk({name, "_result"}, 32'(r), 32'(er));
    chk({name, "_cout"}, 32'(co), 32'(eco));
    chk({name, "_ovf"}, 32'(ov), 32'(eov));
  endtask

  initial begin
    logic [15:0] r, er;
    logic co, ov, eco, eov;
    logic [15:0] ra, rb;
    logic rop, rci;
    int lat;
    int done_seen;

    vecs[0] = '{"add_basic",   16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{"add_ci",      16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2234, 1'b0, 1'b0};
    vecs[2] = '{"add_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{"add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{"sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{"sub_ovf",     16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{"add_negovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{"sub_equal",   16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{"add_ci_wrap", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{"sub_zero_b",  16'hABCD, 16'h0000, 1'b1, 1'b0, 16'hABCD, 1'b1, 1'b0};

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.op = 1'b0; bus.ci = 1'b0;

    // Reset then idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    @(posedge clk); #1;
    chk("idle_done", 32'(bus.done), 32'd0);

    for (int i = 0; i < 10; i++)
      check_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ci,
               vecs[i].res, vecs[i].co, vecs[i].ov);

    // Let the last one fall back to IDLE, and check flags hold there
    @(posedge clk); #1;
    chk("idle_after_done", 32'(bus.done), 32'd0);
    chk("idle_hold_result", 32'(bus.result), 32'(vecs[9].res));

    // start during RUN is ignored
    bus.a = 16'h1111; bus.b = 16'h2222; bus.op = 1'b0; bus.ci = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.op = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 2;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op run_start a=1111 b=2222 -> result=%h lat=%0d", bus.result, lat);
    chk("run_start_latency", 32'(lat), 32'd4);
    chk("run_start_result", 32'(bus.result), 32'h3333);
    @(posedge clk); #1;
    chk("run_start_not_queued", 32'(bus.busy), 32'd0);

    // start held through DONE: back-to-back with no IDLE cycle
    bus.a = 16'h0100; bus.b = 16'h0023; bus.op = 1'b0; bus.ci = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_first_result", 32'(bus.result), 32'h0123);
    bus.a = 16'h0050; bus.b = 16'h0010; bus.op = 1'b1;
    @(posedge clk); #1;
    chk("b2b_accept_busy", 32'(bus.busy), 32'd1);
    chk("b2b_accept_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op b2b a=0050 b=0010 sub -> result=%h lat=%0d", bus.result, lat);
    chk("b2b_second_latency", 32'(lat), 32'd4);
    chk("b2b_second_result", 32'(bus.result), 32'h0040);
    @(posedge clk); #1;

    // Reset asserted in the second RUN cycle
    bus.a = 16'h4321; bus.b = 16'h1111; bus.op = 1'b0; bus.ci = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_result", 32'(bus.result), 32'd0);
    done_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    chk("midrst_no_done", 32'(done_seen), 32'd0);
    check_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 1'($urandom);
      rci = 1'($urandom);
      if (i % 5 == 0) rb = ra;
      ref_op(ra, rb, rop, rci, er, eco, eov);
      check_op($sformatf("rand%0d", i), ra, rb, rop, rci, er, eco, eov);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Multi-cycle wide-word adder/subtractor that reuses a single N-bit add/subtract slice, processing one nibble-wide slice per clock from least significant to most significant and carrying between slices in a register. It sits in front of the N-bit add/sub datapath and sequences it over W-bit operands, giving W-bit add/subtract at the cost of W/N cycles of latency. A simple start/done handshake connects it to the issuing logic.

## Interface
- W, 16, operand/result width in bits; must be a positive multiple of N
- N, 4, slice width processed per cycle
- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- op  input  1  0 = add (a + b + ci), 1 = subtract (a - b); ci ignored when op=1
- a  input  W  operand A, latched when start is accepted
- b  input  W  operand B, latched when start is accepted
- ci  input  1  carry-in for add, latched with the operands
- busy  output  1  high in RUN
- done  output  1  high for exactly one cycle (the DONE state)
- result  output  W  sum/difference; valid while done=1 and held until the next accepted start
- cout  output  1  final carry-out; for subtract, 1 = no borrow (a >= b unsigned)
- ovf  output  1  signed (two's-complement) overflow of the W-bit operation

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: start=1 latches a, b, op, and ci; sets the slice index to 0; loads the carry register with (op ? 1 : ci); goes to RUN.
- RUN: each cycle computes slice i. With y' = op ? ~b_slice : b_slice, the slice sum is s = a_slice ^ y' ^ carry chain, using full-adder carry propagation within the slice.
  - The slice s is written into result[i*N +: N].
  - The slice carry-out is stored in the carry register.
  - The index increments.
  - After slice W/N-1 is written, the state goes to DONE.
- DONE: done=1. cout is the last slice carry-out. ovf = carry into the MSB XOR carry out of the MSB, captured during the last slice.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation) and goes to RUN.
  - Otherwise the state goes to IDLE.
- start during RUN is ignored; it is neither queued nor does it alter the latched operands.
- Inputs a, b, op, and ci may change freely after acceptance.
- Arithmetic is modulo 2^W. Subtract is a + ~b + 1.
- result, cout, and ovf hold their values in IDLE until a new operation begins writing slices.

## Timing
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, slice index=0, carry register=0. Reset takes priority over everything, including mid-RUN (the operation is abandoned, with no done).
- Acceptance edge E0 (start=1 in IDLE or DONE): from E0, busy=1 and done=0.
- Edges E1..E(W/N): slice 0..W/N-1 is committed, one per edge.
- After E(W/N): busy=0 and done=1 for one cycle. Latency from the accepting edge to done is W/N cycles, which is 4 for the default parameters.
- Throughput: one operation per W/N+1 cycles with start held or re-pulsed in DONE.
- result bits of already-processed slices update during RUN. Only values with done=1 are architecturally valid.

## Test plan
- Reset then idle: rst=1 for 2 cycles with start=0 -> busy=0, done=0, result=0x0000, cout=0, ovf=0.
- Add: a=0x1234, b=0x0FFF, op=0, ci=0 -> done exactly 4 cycles after the accept edge, result=0x2233, cout=0, ovf=0. With ci=1 -> result=0x2234.
- Carry ripple across all slices: a=0xFFFF, b=0x0001, op=0, ci=0 -> result=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001 -> result=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, op=1, ci=1 (ignored) -> result=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001, op=1 -> result=0x7FFF, cout=1, ovf=1.
- Handshake:
  - Pulse start with new operands during RUN -> ignored; result matches the first operation.
  - start held in DONE -> the second operation is accepted with no IDLE cycle, and its done arrives 4 cycles later.
- Reset mid-operation: assert rst at the 2nd RUN cycle -> next cycle state=IDLE, busy=0, result=0. No done pulse occurs. A following start with a=0x0001, b=0x0001 (add) yields 0x0002.
